// File: rtl/msg_dispatch_ctrl_if.sv
// Header/handler/acknowledge signal bundle for msg_dispatch_ctrl.
// master: header source, handlers and transmit path; slave: the dispatch controller.
interface msg_dispatch_ctrl_if #(
  parameter int unsigned NUM_HANDLERS = 4
);
  logic                    MessageComplete;
  logic [15:0]             MessageID;
  logic [15:0]             ByteCount;
  logic [15:0]             SequenceNumber;
  logic [NUM_HANDLERS-1:0] HandlerDone;
  logic [NUM_HANDLERS-1:0] HandlerStart;
  logic [2:0]              RamOwner;
  logic [15:0]             PayloadBytes;
  logic                    AckValid;
  logic [15:0]             AckID;
  logic [15:0]             AckSeq;
  logic [1:0]              AckStatus;
  logic                    AckReady;
  logic [7:0]              DropCount;

  modport master (
    output MessageComplete, MessageID, ByteCount, SequenceNumber, HandlerDone, AckReady,
    input  HandlerStart, RamOwner, PayloadBytes, AckValid, AckID, AckSeq, AckStatus, DropCount
  );

  modport slave (
    input  MessageComplete, MessageID, ByteCount, SequenceNumber, HandlerDone, AckReady,
    output HandlerStart, RamOwner, PayloadBytes, AckValid, AckID, AckSeq, AckStatus, DropCount
  );
endinterface

// File: rtl/msg_dispatch_ctrl.sv
// Dispatches completed message headers to one of NUM_HANDLERS handlers and acknowledges them.
// Optional sequence-number checking is enabled by defining MSG_SEQ_CHECK_EN.
module msg_dispatch_ctrl #(
  parameter int unsigned NUM_HANDLERS   = 4,
  parameter logic [15:0] ID_BASE        = 16'h0100,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input logic                Clock,
  input logic                Clear,
  msg_dispatch_ctrl_if.slave bus
);

  localparam int unsigned TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  // The START cycle counts as the first busy cycle, hence the load of TIMEOUT_CYCLES-1.
  localparam logic [TW-1:0] TimerLoad = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {StIdle, StDecode, StStart, StWaitDone, StAck} state_e;

  state_e            state_q, state_d;
  logic [15:0]       id_q, id_d;
  logic [15:0]       seq_q, seq_d;
  logic [15:0]       payload_q, payload_d;
  logic [2:0]        owner_q, owner_d;
  logic [1:0]        status_q, status_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [7:0]        drop_q, drop_d;
  logic [15:0]       idx_full;
  logic              id_ok;
  logic              seq_bad;
  logic              done_hit;
  logic [NUM_HANDLERS-1:0] sel_mask;

  assign idx_full = id_q - ID_BASE;
  assign id_ok    = idx_full < 16'(NUM_HANDLERS);

  always_comb begin
    sel_mask = '0;
    for (int unsigned i = 0; i < NUM_HANDLERS; i++) begin
      sel_mask[i] = (owner_q == 3'(i));
    end
  end

  assign done_hit = |(bus.HandlerDone & sel_mask);

`ifdef MSG_SEQ_CHECK_EN
  logic [15:0] exp_seq_q, exp_seq_d;
  logic        first_q, first_d;

  assign seq_bad = !first_q && (seq_q != exp_seq_q);

  // Only messages that reach START advance the expected sequence number.
  always_comb begin
    exp_seq_d = exp_seq_q;
    first_d   = first_q;
    if (state_q == StStart) begin
      exp_seq_d = seq_q + 16'd1;
      first_d   = 1'b0;
    end
  end

  always_ff @(posedge Clock) begin
    if (Clear) begin
      exp_seq_q <= '0;
      first_q   <= 1'b1;
    end else begin
      exp_seq_q <= exp_seq_d;
      first_q   <= first_d;
    end
  end
`else
  assign seq_bad = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    id_d      = id_q;
    seq_d     = seq_q;
    payload_d = payload_q;
    owner_d   = owner_q;
    status_d  = status_q;
    timer_d   = timer_q;
    drop_d    = drop_q;

    if (bus.MessageComplete && (state_q != StIdle) && (drop_q != 8'hFF)) begin
      drop_d = drop_q + 8'd1;
    end

    unique case (state_q)
      StIdle: begin
        if (bus.MessageComplete) begin
          id_d      = bus.MessageID;
          seq_d     = bus.SequenceNumber;
          payload_d = bus.ByteCount - 16'd8;
          state_d   = StDecode;
        end
      end
      StDecode: begin
        if (!id_ok) begin
          status_d = 2'd1;
          state_d  = StAck;
        end else if (seq_bad) begin
          status_d = 2'd3;
          state_d  = StAck;
        end else begin
          owner_d = idx_full[2:0];
          state_d = StStart;
        end
      end
      StStart: begin
        timer_d = TimerLoad;
        state_d = StWaitDone;
      end
      StWaitDone: begin
        // A done that lands on the expiry cycle still counts as success.
        if (done_hit) begin
          status_d = 2'd0;
          state_d  = StAck;
        end else if (timer_q <= TW'(1)) begin
          status_d = 2'd2;
          state_d  = StAck;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      StAck: begin
        if (bus.AckReady) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Clear) begin
      state_q   <= StIdle;
      id_q      <= '0;
      seq_q     <= '0;
      payload_q <= '0;
      owner_q   <= '0;
      status_q  <= '0;
      timer_q   <= '0;
      drop_q    <= '0;
    end else begin
      state_q   <= state_d;
      id_q      <= id_d;
      seq_q     <= seq_d;
      payload_q <= payload_d;
      owner_q   <= owner_d;
      status_q  <= status_d;
      timer_q   <= timer_d;
      drop_q    <= drop_d;
    end
  end

  assign bus.HandlerStart = (state_q == StStart) ? sel_mask : '0;
  assign bus.RamOwner     = owner_q;
  assign bus.PayloadBytes = payload_q;
  assign bus.AckValid     = (state_q == StAck);
  assign bus.AckID        = id_q;
  assign bus.AckSeq       = seq_q;
  assign bus.AckStatus    = status_q;
  assign bus.DropCount    = drop_q;

endmodule

// File: tb/tb_msg_dispatch_ctrl.sv
// Randomized scoreboard bench for msg_dispatch_ctrl with a message-level reference model.
module tb_msg_dispatch_ctrl;
  localparam int          NH   = 4;
  localparam logic [15:0] BASE = 16'h0100;
  localparam int          TO   = 10;
`ifdef MSG_SEQ_CHECK_EN
  localparam bit SEQ = 1'b1;
`else
  localparam bit SEQ = 1'b0;
`endif

  logic clk = 1'b0;
  logic clr = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  msg_dispatch_ctrl_if #(.NUM_HANDLERS(NH)) bus ();

  msg_dispatch_ctrl #(
    .NUM_HANDLERS  (NH),
    .ID_BASE       (BASE),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .Clock(clk),
    .Clear(clr),
    .bus  (bus)
  );

  typedef struct {
    logic [NH-1:0] hot;
    logic [2:0]    owner;
    logic [15:0]   payload;
    int            c;
  } start_t;

  typedef struct {
    logic [15:0] id;
    logic [15:0] seq;
    logic [15:0] payload;
    logic [1:0]  st;
    int          c;
  } ack_t;

  start_t sq[$];
  ack_t   aq[$];
  start_t se;
  ack_t   ae;

  // Reference model state
  int          drops_m = 0;
  bit          first_m = 1'b1;
  logic [15:0] last_m  = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: pops expectations whenever the DUT starts a handler or completes an ack.
  bit          ack_prev = 1'b0;
  bit          changed  = 1'b0;
  int          rise_c   = 0;
  logic [15:0] l_id, l_seq;
  logic [1:0]  l_st;

  always @(negedge clk) begin
    if (clr) begin
      ack_prev = 1'b0;
    end else begin
      if (bus.HandlerStart != '0) begin
        if (sq.size() == 0) begin
          chk("unexpected_start", 32'(bus.HandlerStart), 32'd0);
        end else begin
          se = sq.pop_front();
          chk("start_onehot", 32'(bus.HandlerStart), 32'(se.hot));
          chk("start_cycle", 32'(cyc), 32'(se.c));
          chk("ram_owner", 32'(bus.RamOwner), 32'(se.owner));
          chk("payload_at_start", 32'(bus.PayloadBytes), 32'(se.payload));
        end
      end
      if (bus.AckValid) begin
        if (!ack_prev) begin
          rise_c  = cyc;
          l_id    = bus.AckID;
          l_seq   = bus.AckSeq;
          l_st    = bus.AckStatus;
          changed = 1'b0;
        end else if (l_id !== bus.AckID || l_seq !== bus.AckSeq || l_st !== bus.AckStatus) begin
          changed = 1'b1;
        end
        if (bus.AckReady) begin
          if (aq.size() == 0) begin
            chk("unexpected_ack", 32'(bus.AckValid), 32'd0);
          end else begin
            ae = aq.pop_front();
            chk("ack_id", 32'(bus.AckID), 32'(ae.id));
            chk("ack_seq", 32'(bus.AckSeq), 32'(ae.seq));
            chk("ack_status", 32'(bus.AckStatus), 32'(ae.st));
            chk("ack_payload", 32'(bus.PayloadBytes), 32'(ae.payload));
            chk("ack_cycle", 32'(rise_c), 32'(ae.c));
            chk("ack_stable", 32'(changed), 32'd0);
          end
        end
      end
      ack_prev = bus.AckValid;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_checks();
    chk("rst_handler_start", 32'(bus.HandlerStart), 32'd0);
    chk("rst_ack_valid", 32'(bus.AckValid), 32'd0);
    chk("rst_ack_id", 32'(bus.AckID), 32'd0);
    chk("rst_ack_seq", 32'(bus.AckSeq), 32'd0);
    chk("rst_ack_status", 32'(bus.AckStatus), 32'd0);
    chk("rst_ram_owner", 32'(bus.RamOwner), 32'd0);
    chk("rst_payload", 32'(bus.PayloadBytes), 32'd0);
    chk("rst_drop_count", 32'(bus.DropCount), 32'd0);
  endtask

  task automatic do_clear();
    clr = 1'b1;
    step();
    clr     = 1'b0;
    drops_m = 0;
    first_m = 1'b1;
    reset_checks();
  endtask

  function automatic int sat_inc(input int v);
    return (v < 255) ? v + 1 : 255;
  endfunction

  // One message: dk = done delay after HandlerStart (0 = never), hold = AckReady low cycles,
  // ndrop = extra MessageComplete pulses during hold, xdrop = pulse on the ack exit cycle,
  // clr_k = assert Clear k cycles after HandlerStart instead of completing.
  task automatic run_msg(input logic [15:0] id, input logic [15:0] seq, input logic [15:0] bc,
                         input int dk, input int hold, input int ndrop, input bit xdrop,
                         input int clr_k);
    int            m, s, idx, ac, n;
    bit            valid, started;
    logic [1:0]    st;
    logic [NH-1:0] hot;
    start_t        sx;
    ack_t          ax;

    step();
    bus.MessageComplete = 1'b1;
    bus.MessageID       = id;
    bus.SequenceNumber  = seq;
    bus.ByteCount       = bc;
    m       = cyc;
    s       = m + 2;
    idx     = int'(id) - int'(BASE);
    valid   = (idx >= 0) && (idx < NH);
    started = 1'b0;
    hot     = '0;
    if (!valid) begin
      st = 2'd1;
      ac = m + 2;
    end else if (SEQ && !first_m && seq != 16'(last_m + 16'd1)) begin
      st = 2'd3;
      ac = m + 2;
    end else begin
      started = 1'b1;
      first_m = 1'b0;
      last_m  = seq;
      hot     = NH'(1) << idx;
      if (dk >= 1 && dk <= TO - 1) begin
        st = 2'd0;
        ac = s + dk + 1;
      end else begin
        st = 2'd2;
        ac = s + TO;
      end
      sx = '{hot: hot, owner: 3'(idx), payload: bc - 16'd8, c: s};
      sq.push_back(sx);
    end
    if (clr_k == 0) begin
      ax = '{id: id, seq: seq, payload: bc - 16'd8, st: st, c: ac};
      aq.push_back(ax);
    end
    step();
    bus.MessageComplete = 1'b0;
    bus.MessageID       = 16'($urandom);
    bus.SequenceNumber  = 16'($urandom);
    bus.ByteCount       = 16'($urandom);

    if (clr_k > 0 && started) begin
      while (cyc < s + clr_k) step();
      do_clear();
      return;
    end

    if (started && dk > 0) begin
      n = 0;
      while (cyc < s + dk && n < 100) begin
        bus.HandlerDone = NH'($urandom) & ~hot;
        step();
        n++;
      end
      bus.HandlerDone = hot;
      step();
      bus.HandlerDone = '0;
    end

    n = 0;
    while (!bus.AckValid && n < 60) begin
      step();
      n++;
    end
    if (!bus.AckValid) begin
      chk("ack_wait_timeout", 32'(bus.AckValid), 32'd1);
      aq.delete();
      do_clear();
      return;
    end

    for (int i = 0; i < hold; i++) begin
      if (i < 2 * ndrop && (i % 2) == 0) begin
        bus.MessageComplete = 1'b1;
        drops_m = sat_inc(drops_m);
      end else begin
        bus.MessageComplete = 1'b0;
      end
      step();
    end
    bus.MessageComplete = xdrop;
    if (xdrop) drops_m = sat_inc(drops_m);
    bus.AckReady = 1'b1;
    step();
    bus.AckReady        = 1'b0;
    bus.MessageComplete = 1'b0;
    chk("ack_released", 32'(bus.AckValid), 32'd0);
    chk("drop_count", 32'(bus.DropCount), 32'(drops_m));
  endtask

  initial begin
    int          r, dk, hold;
    logic [15:0] id, sqn;

    bus.MessageComplete = 1'b0;
    bus.MessageID       = '0;
    bus.ByteCount       = '0;
    bus.SequenceNumber  = '0;
    bus.HandlerDone     = '0;
    bus.AckReady        = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    clr = 1'b0;
    reset_checks();

    run_msg(16'h0101, 16'd5, 16'd12, 4, 0, 0, 1'b0, 0);   // handler 1, payload 4, status 0
    run_msg(16'h0200, 16'd6, 16'd20, 3, 1, 0, 1'b0, 0);   // unknown ID
    run_msg(16'h00FF, 16'd6, 16'd20, 3, 0, 0, 1'b0, 0);   // below base wraps: unknown
    run_msg(16'h0102, 16'd6, 16'd30, 0, 0, 0, 1'b0, 0);   // timeout
    run_msg(16'h0103, 16'd7, 16'd9, TO - 1, 0, 0, 1'b0, 0); // done on expiry cycle
    run_msg(16'h0100, 16'd8, 16'd40, 2, 20, 3, 1'b0, 0);  // held ack with three drops
    run_msg(16'h0101, 16'd9, 16'd16, 1, 2, 0, 1'b1, 0);   // drop on ack exit cycle

    do_clear();
    run_msg(16'h0100, 16'd7, 16'd10, 2, 0, 0, 1'b0, 0);
    run_msg(16'h0101, 16'd8, 16'd10, 2, 0, 0, 1'b0, 0);
    run_msg(16'h0102, 16'd10, 16'd10, 2, 0, 0, 1'b0, 0);  // sequence gap
    do_clear();
    run_msg(16'h0103, 16'hFFFF, 16'd8, 3, 0, 0, 1'b0, 0);
    run_msg(16'h0100, 16'h0000, 16'd8, 3, 0, 0, 1'b0, 0); // wraps to zero

    run_msg(16'h0102, 16'h1234, 16'd20, 0, 0, 0, 1'b0, 3); // Clear during WAIT_DONE
    run_msg(16'h0101, 16'h4321, 16'd50, 5, 0, 0, 1'b0, 0);
    run_msg(16'h0100, 16'h4322, 16'd50, 1, 600, 300, 1'b0, 0); // DropCount saturation
    do_clear();

    for (int k = 0; k < 40; k++) begin
      r = int'($urandom_range(0, 9));
      if (r < 6) id = BASE + 16'(r % 4);
      else if (r < 8) id = BASE + 16'($urandom_range(4, 300));
      else id = 16'($urandom);
      sqn  = ($urandom_range(0, 3) != 0) ? 16'(last_m + 16'd1) : 16'($urandom);
      dk   = int'($urandom_range(0, 13));
      hold = int'($urandom_range(0, 4));
      run_msg(id, sqn, 16'($urandom), dk, hold, int'($urandom_range(0, hold / 2)),
              1'($urandom_range(0, 1)), 0);
    end

    repeat (3) step();
    chk("start_queue_drained", 32'(sq.size()), 32'd0);
    chk("ack_queue_drained", 32'(aq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
